// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types: FSM states, MEM/WB bundle,
// alignment mask and timeout counter width.
package mem_stage_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem2reg;
    logic        fault;
    logic [4:0]  rd;
    logic [63:0] alu_out;
    logic [63:0] read_data;
  } mem_wb_t;

  localparam logic [2:0] ALIGN_MASK = 3'b111;
  localparam int         CNT_W      = 8;

  function automatic logic is_misaligned(
    input logic [63:0] addr
  );
    return (addr[2:0] & ALIGN_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears
// every field so writeback sees a no-op.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // load next bundle, or zeros on bubble/reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: dmem handshake FSM, timeout and
// fault detection, feeding the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        Valid_MEM,
  input  logic        RegWrite_MEM,
  input  logic        Mem2Reg_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [4:0]  RD_MEM,
  input  logic [63:0] ALUout_MEM,
  input  logic [63:0] WriteData_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic        Stall_MEM,
  output logic        RegWrite_WB,
  output logic        Mem2Reg_WB,
  output logic [4:0]  RD_WB,
  output logic [63:0] ALUout_WB,
  output logic [63:0] ReadData_WB,
  output logic        Fault_WB
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic    mem_op;
  logic    misaligned;
  logic    aligned_op;
  logic    is_store;
  logic    req_raw;
  logic    timeout_hit;
  logic    load_done;
  logic    fault;
  logic    bubble;
  mem_wb_t wb_d;
  mem_wb_t wb_q;

  assign mem_op     = Valid_MEM &
                      (MemRead_MEM | MemWrite_MEM);
  assign misaligned = is_misaligned(ALUout_MEM);
  assign aligned_op = mem_op & ~misaligned;
  // read+write together behaves as a store
  assign is_store   = MemWrite_MEM;

  // state and timeout counter
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state, raw request and timeout detect
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_raw     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_raw = aligned_op;
        if (aligned_op && !dmem_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        req_raw     = 1'b1;
        timeout_hit = ~dmem_ready &
                      (cnt == CNT_LAST);
        if (!dmem_ready) begin
          cnt_nxt = cnt + 1'b1;
        end
        if (dmem_ready || timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // reset must silence the request immediately
  assign dmem_req   = resetl & req_raw;
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = dmem_req ? ALUout_MEM : '0;
  assign dmem_wdata = dmem_req ? WriteData_MEM : '0;

  assign Stall_MEM  = dmem_req & ~dmem_ready &
                      ~timeout_hit;

  assign load_done  = dmem_req & dmem_ready &
                      ~is_store;
  assign fault      = (mem_op & misaligned) |
                      timeout_hit;
  assign bubble     = Stall_MEM | ~Valid_MEM;

  // assemble the bundle headed for writeback
  always_comb begin
    wb_d           = '0;
    wb_d.reg_write = Valid_MEM & RegWrite_MEM &
                     ~fault;
    wb_d.mem2reg   = Mem2Reg_MEM;
    wb_d.fault     = fault;
    wb_d.rd        = RD_MEM;
    wb_d.alu_out   = ALUout_MEM;
    unique case (1'b1)
      load_done: wb_d.read_data = dmem_rdata;
      default:   wb_d.read_data = '0;
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst_n  (resetl),
    .bubble (bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign RegWrite_WB = wb_q.reg_write;
  assign Mem2Reg_WB  = wb_q.mem2reg;
  assign Fault_WB    = wb_q.fault;
  assign RD_WB       = wb_q.rd;
  assign ALUout_WB   = wb_q.alu_out;
  assign ReadData_WB = wb_q.read_data;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a
// transaction-level latency/fault model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetl;
  logic        Valid_MEM;
  logic        RegWrite_MEM;
  logic        Mem2Reg_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [4:0]  RD_MEM;
  logic [63:0] ALUout_MEM;
  logic [63:0] WriteData_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        Stall_MEM;
  logic        RegWrite_WB;
  logic        Mem2Reg_WB;
  logic [4:0]  RD_WB;
  logic [63:0] ALUout_WB;
  logic [63:0] ReadData_WB;
  logic        Fault_WB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic        rw;
    logic        m2r;
    logic        rd_en;
    logic        wr_en;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [63:0] rdata;
    int          lat;
  } instr_t;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .resetl        (resetl),
    .Valid_MEM     (Valid_MEM),
    .RegWrite_MEM  (RegWrite_MEM),
    .Mem2Reg_MEM   (Mem2Reg_MEM),
    .MemRead_MEM   (MemRead_MEM),
    .MemWrite_MEM  (MemWrite_MEM),
    .RD_MEM        (RD_MEM),
    .ALUout_MEM    (ALUout_MEM),
    .WriteData_MEM (WriteData_MEM),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .Stall_MEM     (Stall_MEM),
    .RegWrite_WB   (RegWrite_WB),
    .Mem2Reg_WB    (Mem2Reg_WB),
    .RD_WB         (RD_WB),
    .ALUout_WB     (ALUout_WB),
    .ReadData_WB   (ReadData_WB),
    .Fault_WB      (Fault_WB)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] wb_ctl();
    return {RegWrite_WB, Mem2Reg_WB,
            Fault_WB, RD_WB};
  endfunction

  task automatic check_wb_zero(input string tag);
    check({tag, "_ctl"}, 64'(wb_ctl()), 64'd0);
    check({tag, "_alu"}, ALUout_WB, 64'd0);
    check({tag, "_rdat"}, ReadData_WB, 64'd0);
  endtask

  task automatic drive(input instr_t t);
    Valid_MEM     = t.v;
    RegWrite_MEM  = t.rw;
    Mem2Reg_MEM   = t.m2r;
    MemRead_MEM   = t.rd_en;
    MemWrite_MEM  = t.wr_en;
    RD_MEM        = t.rd;
    ALUout_MEM    = t.alu;
    WriteData_MEM = t.wd;
  endtask

  // One instruction: the model derives how many
  // cycles it occupies MEM and what reaches WB.
  task automatic run(input instr_t t);
    logic memop;
    logic mis;
    logic ok_lat;
    logic flt;
    logic live;
    int   occ;
    logic [7:0]  e_ctl;
    logic [63:0] e_alu;
    logic [63:0] e_rd;
    memop  = t.v & (t.rd_en | t.wr_en);
    mis    = t.alu % 8 != 0;
    live   = memop & ~mis;
    ok_lat = t.lat >= 1 && t.lat <= TO + 1;
    if (!live)       occ = 1;
    else if (ok_lat) occ = t.lat;
    else             occ = TO + 1;
    flt = memop & (mis | ~ok_lat);
    if (!t.v) begin
      e_ctl = 8'd0;
      e_alu = 64'd0;
      e_rd  = 64'd0;
    end else begin
      e_ctl = {t.rw & ~flt, t.m2r, flt, t.rd};
      e_alu = t.alu;
      e_rd  = (memop && !flt && !t.wr_en) ?
              t.rdata : 64'd0;
    end
    for (int k = 1; k <= occ; k++) begin
      @(negedge clk);
      drive(t);
      if (live) begin
        dmem_ready = (t.lat == k);
        dmem_rdata = (t.lat == k) ? t.rdata :
                     {$urandom, $urandom};
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = {$urandom, $urandom};
      end
      #1;
      check("req", 64'(dmem_req), 64'(live));
      check("stall", 64'(Stall_MEM),
            64'(k < occ));
      check("we", 64'(dmem_we),
            64'(live & t.wr_en));
      check("addr", dmem_addr,
            live ? t.alu : 64'd0);
      check("wdata", dmem_wdata,
            live ? t.wd : 64'd0);
      @(posedge clk);
      #1;
      if (k < occ) begin
        check_wb_zero("bub");
      end else begin
        check("wb_ctl", 64'(wb_ctl()),
              64'(e_ctl));
        check("wb_alu", ALUout_WB, e_alu);
        check("wb_rdat", ReadData_WB, e_rd);
      end
    end
  endtask

  function automatic instr_t mk(
    input logic v, input logic rw,
    input logic m2r, input logic r,
    input logic w, input logic [4:0] rd,
    input logic [63:0] alu,
    input logic [63:0] wd,
    input logic [63:0] rdata, input int lat
  );
    instr_t t;
    t.v = v; t.rw = rw; t.m2r = m2r;
    t.rd_en = r; t.wr_en = w; t.rd = rd;
    t.alu = alu; t.wd = wd;
    t.rdata = rdata; t.lat = lat;
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    int kind;
    kind = $urandom_range(0, 3);
    t.v     = $urandom_range(0, 7) != 0;
    t.rw    = 1'($urandom_range(0, 1));
    t.m2r   = 1'($urandom_range(0, 1));
    t.rd_en = kind == 1 || kind == 3;
    t.wr_en = kind == 2 || kind == 3;
    t.rd    = 5'($urandom_range(0, 31));
    t.alu   = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0)
      t.alu[2:0] = 3'b000;
    t.wd    = {$urandom, $urandom};
    t.rdata = {$urandom, $urandom};
    t.lat   = $urandom_range(0, TO + 2);
    return t;
  endfunction

  initial begin
    resetl     = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive(mk(1, 1, 1, 1, 0, 5'd3, 64'h40,
             64'd0, 64'd0, 1));
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_stall", 64'(Stall_MEM), 64'd0);
    check_wb_zero("rst");
    @(negedge clk);
    Valid_MEM = 1'b0;
    resetl    = 1'b1;

    // ALU op
    run(mk(1, 1, 0, 0, 0, 5'd5, 64'h1234,
           64'd0, 64'd0, 1));
    // load, ready in cycle 3
    run(mk(1, 1, 1, 1, 0, 5'd7, 64'h40,
           64'd0, 64'hDEADBEEF, 3));
    // zero-wait store
    run(mk(1, 0, 0, 0, 1, 5'd0, 64'h80,
           64'hAA, 64'd0, 1));
    // misaligned load
    run(mk(1, 1, 1, 1, 0, 5'd9, 64'h43,
           64'd0, 64'd0, 1));
    // ready never arrives
    run(mk(1, 1, 1, 1, 0, 5'd10, 64'h100,
           64'd0, 64'h55, 0));
    // ready in the timeout cycle
    run(mk(1, 1, 1, 1, 0, 5'd11, 64'h108,
           64'd0, 64'h77, TO + 1));
    // ready one cycle too late
    run(mk(1, 1, 0, 0, 1, 5'd12, 64'h110,
           64'h99, 64'd0, TO + 2));
    // invalid slot carrying a mem op
    run(mk(0, 1, 1, 1, 0, 5'd13, 64'h118,
           64'd0, 64'd0, 1));

    // asynchronous clear of a live WB entry
    run(mk(1, 1, 0, 0, 0, 5'd14, 64'hF00,
           64'd0, 64'd0, 1));
    #2;
    drive(mk(1, 1, 1, 1, 0, 5'd15, 64'h200,
             64'd0, 64'd0, 1));
    resetl = 1'b0;
    #1;
    check("arst_req", 64'(dmem_req), 64'd0);
    check("arst_stall", 64'(Stall_MEM), 64'd0);
    check_wb_zero("arst");
    @(negedge clk);
    Valid_MEM = 1'b0;
    resetl    = 1'b1;

    // reset while waiting on memory
    @(negedge clk);
    drive(mk(1, 1, 1, 1, 0, 5'd16, 64'h300,
             64'd0, 64'd0, 0));
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("wait_stall", 64'(Stall_MEM), 64'd1);
    #2;
    resetl = 1'b0;
    #1;
    check("wrst_req", 64'(dmem_req), 64'd0);
    check("wrst_stall", 64'(Stall_MEM), 64'd0);
    @(posedge clk);
    #1;
    check_wb_zero("wrst");
    @(negedge clk);
    Valid_MEM = 1'b0;
    resetl    = 1'b1;
    run(mk(1, 1, 0, 0, 0, 5'd17, 64'h5A5A,
           64'd0, 64'd0, 1));
    run(mk(1, 1, 1, 1, 0, 5'd18, 64'h308,
           64'd0, 64'hCAFE, 2));

    for (int i = 0; i < 300; i++) begin
      run(rnd());
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
